// File: rtl/settle_pkg.sv
// -----------------------------------------------------------------------------
// settle_pkg
//   Shared types and helpers for the settle_monitor block.
//   - state_t   : tracking FSM states.
//   - MAX_POS / MAX_NEG : full-scale extremes of the default 18-bit fixed-point
//                 real format.
//   - abs_wide(): magnitude of a sign-extended error word. The caller
//                 sign-extends to ABS_W bits and slices the result back, so one
//                 helper serves any WIDTH up to ABS_W-1.
// -----------------------------------------------------------------------------
package settle_pkg;

  localparam int DEF_WIDTH = 18;
  localparam int ABS_W     = 64;

  localparam logic signed [DEF_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    SETTLED = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Inputs are at most a few tens of bits wide, so the most negative ABS_W
  // value never reaches this function and negation cannot overflow.
  function automatic logic [ABS_W-1:0] abs_wide(input logic signed [ABS_W-1:0] x);
    logic signed [ABS_W-1:0] neg_x;
    neg_x = -x;
    return x[ABS_W-1] ? $unsigned(neg_x) : $unsigned(x);
  endfunction

endpackage

// File: rtl/settle_monitor_band_cmp.sv
// -----------------------------------------------------------------------------
// band_cmp
//   Purely combinational tolerance-band check:
//     in_band = |v_in - target| <= tol
//   The difference is formed in WIDTH+1 bits so that a target and sample at
//   opposite full-scale extremes cannot wrap into a small error.
// Ports
//   v_in    in  WIDTH  signed sample under test
//   target  in  WIDTH  signed expected value
//   tol     in  WIDTH  unsigned band half-width
//   in_band out 1      sample lies inside the closed band
// -----------------------------------------------------------------------------
module band_cmp
  import settle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] v_in,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  output logic                    in_band
);

  logic signed [WIDTH:0]   err;
  logic signed [ABS_W-1:0] err_ext;
  logic        [ABS_W-1:0] mag_full;
  logic        [WIDTH:0]   mag;
  logic                    mag_fits;

  always_comb begin
    // One guard bit on each operand keeps the subtraction exact.
    err      = $signed({v_in[WIDTH-1], v_in}) - $signed({target[WIDTH-1], target});
    err_ext  = ABS_W'(err);
    mag_full = abs_wide(err_ext);
    mag      = mag_full[WIDTH:0];
    // |err| <= 2^WIDTH always, so the upper bits are zero; checking them keeps
    // the compare honest if the slice width is ever changed.
    mag_fits = (mag_full[ABS_W-1:WIDTH+1] == '0);
    in_band  = mag_fits && (mag <= {1'b0, tol});
  end

endmodule

// File: rtl/settle_monitor.sv
// -----------------------------------------------------------------------------
// settle_monitor
//   Watches a fixed-point real model output and decides whether it has settled
//   to within +/-tol of a target for HOLD_CYC consecutive samples. Reports the
//   index of the first sample of the final in-band run, the min/max excursion
//   seen while tracking, and a timeout after MAX_CYC tracking samples.
//
//   start (any state) latches target/tol and enters TRACK; the first sample
//   is taken on the following clock edge (cycle index 1). start always wins
//   over any other transition on the same edge.
//
// Parameters
//   WIDTH     bit width of signed fixed-point v_in/target (and unsigned tol)
//   EXPONENT  shared binary exponent of v_in/target/tol (informational only)
//   HOLD_CYC  consecutive in-band samples needed to declare settled (>=1)
//   MAX_CYC   tracking samples before timeout (>HOLD_CYC)
//   CNT_W     width of the cycle counter / settle_cycles
//
// Ports
//   clk            in   model clock
//   rst_n          in   async active-low reset
//   start          in   1-cycle pulse: latch target/tol, begin tracking
//   target         in   signed expected final value
//   tol            in   unsigned band half-width
//   v_in           in   signed model output under test
//   busy           out  high while tracking
//   done           out  1-cycle pulse on entry to SETTLED or TIMEOUT
//   settled        out  level, high in SETTLED
//   timeout        out  level, high in TIMEOUT
//   settle_cycles  out  index of first sample of the final in-band run
//   v_min, v_max   out  signed extremes of v_in seen while tracking
// -----------------------------------------------------------------------------
module settle_monitor
  import settle_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int EXPONENT = -12,
  parameter int HOLD_CYC = 4,
  parameter int MAX_CYC  = 1024,
  parameter int CNT_W    = $clog2(MAX_CYC + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  input  logic signed [WIDTH-1:0] v_in,
  output logic                    busy,
  output logic                    done,
  output logic                    settled,
  output logic                    timeout,
  output logic        [CNT_W-1:0] settle_cycles,
  output logic signed [WIDTH-1:0] v_min,
  output logic signed [WIDTH-1:0] v_max
);

  // Width of the consecutive in-band counter; it saturates at HOLD_CYC.
  localparam int STB_W = $clog2(HOLD_CYC + 1);

  localparam logic signed [WIDTH-1:0] POS_FS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_FS = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [STB_W-1:0] HOLD_LIM = STB_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_CYC);

  // Elaboration-time guard against parameter sets the FSM cannot honour.
  if (HOLD_CYC < 1 || MAX_CYC <= HOLD_CYC || CNT_W < $clog2(MAX_CYC + 1) ||
      EXPONENT < -1024 || EXPONENT > 1024) begin : g_param_check
    $error("settle_monitor: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cyc_q, cyc_d;
  logic        [STB_W-1:0]   stable_q, stable_d;
  logic        [CNT_W-1:0]   settle_cycles_q, settle_cycles_d;
  logic signed [WIDTH-1:0]   v_min_q, v_min_d;
  logic signed [WIDTH-1:0]   v_max_q, v_max_d;
  logic signed [WIDTH-1:0]   target_q, target_d;
  logic        [WIDTH-1:0]   tol_q, tol_d;
  logic                      done_q, done_d;

  logic                      in_band;

  // ---------------------------------------------------------------------------
  // Band check against the latched target/tol
  // ---------------------------------------------------------------------------
  band_cmp #(
    .WIDTH (WIDTH)
  ) u_band_cmp (
    .v_in    (v_in),
    .target  (target_q),
    .tol     (tol_q),
    .in_band (in_band)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    cyc_d           = cyc_q;
    stable_d        = stable_q;
    settle_cycles_d = settle_cycles_q;
    v_min_d         = v_min_q;
    v_max_d         = v_max_q;
    target_d        = target_q;
    tol_d           = tol_q;
    done_d          = 1'b0;

    if (start) begin
      // Restart from any state. min/max are seeded at the opposite extremes so
      // the first tracked sample overwrites both. settle_cycles is left alone;
      // it only moves when a new in-band run begins.
      state_d  = TRACK;
      cyc_d    = '0;
      stable_d = '0;
      v_min_d  = POS_FS;
      v_max_d  = NEG_FS;
      target_d = target;
      tol_d    = tol;
    end else if (state_q == TRACK) begin
      cyc_d = cyc_q + CNT_W'(1);

      if (in_band) begin
        if (stable_q != HOLD_LIM) begin
          stable_d = stable_q + STB_W'(1);
        end
        // A run starts on the 0 -> 1 transition of the stable count.
        if (stable_q == '0) begin
          settle_cycles_d = cyc_d;
        end
      end else begin
        stable_d = '0;
      end

      if (v_in < v_min_q) begin
        v_min_d = v_in;
      end
      if (v_in > v_max_q) begin
        v_max_d = v_in;
      end

      // Settling is tested first so a run completing on the last allowed
      // sample is reported as SETTLED rather than TIMEOUT.
      if (stable_d == HOLD_LIM) begin
        state_d = SETTLED;
        done_d  = 1'b1;
      end else if (cyc_d == MAX_LIM) begin
        state_d = TIMEOUT;
        done_d  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      stable_q        <= '0;
      settle_cycles_q <= '0;
      v_min_q         <= '0;
      v_max_q         <= '0;
      target_q        <= '0;
      tol_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      stable_q        <= stable_d;
      settle_cycles_q <= settle_cycles_d;
      v_min_q         <= v_min_d;
      v_max_q         <= v_max_d;
      target_q        <= target_d;
      tol_q           <= tol_d;
      done_q          <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight decode of registered state, no extra pipeline stage
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (state_q == TRACK);
    settled       = (state_q == SETTLED);
    timeout       = (state_q == TIMEOUT);
    done          = done_q;
    settle_cycles = settle_cycles_q;
    v_min         = v_min_q;
    v_max         = v_max_q;
  end

endmodule

// File: tb/tb_settle_monitor.sv
// -----------------------------------------------------------------------------
// tb_settle_monitor
//   Scoreboarded bench for settle_monitor (WIDTH=18, HOLD_CYC=4, MAX_CYC=64).
//   The stimulus thread fills a per-transaction sample table, asks a reference
//   model for the outcome and pushes it onto a queue; a monitor on the falling
//   edge pops and compares whenever done pulses.
//   The model works on the whole sample table: it looks for the first window
//   of HOLD_CYC consecutive in-band samples, then derives the run start and
//   extremes by scanning the samples up to that point.
// -----------------------------------------------------------------------------
module tb_settle_monitor;

  localparam int WIDTH    = 18;
  localparam int HOLD_CYC = 4;
  localparam int MAX_CYC  = 64;
  localparam int CNT_W    = 7;
  localparam int FS_POS   = 131071;
  localparam int FS_NEG   = -131072;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic signed [WIDTH-1:0] target_i = '0;
  logic        [WIDTH-1:0] tol_i = '0;
  logic signed [WIDTH-1:0] v_in = '0;
  logic                    busy, done, settled, timeout;
  logic        [CNT_W-1:0] settle_cycles;
  logic signed [WIDTH-1:0] v_min, v_max;

  settle_monitor #(
    .WIDTH    (WIDTH),
    .EXPONENT (-12),
    .HOLD_CYC (HOLD_CYC),
    .MAX_CYC  (MAX_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .target        (target_i),
    .tol           (tol_i),
    .v_in          (v_in),
    .busy          (busy),
    .done          (done),
    .settled       (settled),
    .timeout       (timeout),
    .settle_cycles (settle_cycles),
    .v_min         (v_min),
    .v_max         (v_max)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read only on falling edges.
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int done_edge;  // absolute rising-edge count at which done must appear
    int k_end;      // sample index of the terminating edge
    bit settled;
    int sc;
    int vmin;
    int vmax;
  } exp_t;

  int   samp [1:MAX_CYC];
  int   held_sc = 0;   // settle_cycles carried over between transactions
  exp_t sb_q [$];

  function automatic bit in_band_m(input int v, input int t, input int tl);
    int d;
    d = v - t;
    if (d < 0) d = -d;
    return d <= tl;
  endfunction

  function automatic exp_t model(input int t, input int tl);
    exp_t e;
    bit   window_ok;
    e.done_edge = 0;
    e.k_end     = MAX_CYC;
    e.settled   = 1'b0;
    for (int k = HOLD_CYC; k <= MAX_CYC && !e.settled; k++) begin
      window_ok = 1'b1;
      for (int j = k - HOLD_CYC + 1; j <= k; j++)
        if (!in_band_m(samp[j], t, tl)) window_ok = 1'b0;
      if (window_ok) begin
        e.settled = 1'b1;
        e.k_end   = k;
      end
    end
    e.sc = held_sc;
    for (int k = 1; k <= e.k_end; k++)
      if (in_band_m(samp[k], t, tl) && (k == 1 || !in_band_m(samp[k-1], t, tl)))
        e.sc = k;
    e.vmin = samp[1];
    e.vmax = samp[1];
    for (int k = 2; k <= e.k_end; k++) begin
      if (samp[k] < e.vmin) e.vmin = samp[k];
      if (samp[k] > e.vmax) e.vmax = samp[k];
    end
    return e;
  endfunction

  function automatic int clamp(input int v);
    if (v > FS_POS) return FS_POS;
    if (v < FS_NEG) return FS_NEG;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares on every done pulse, independent of the stimulus thread
  // ---------------------------------------------------------------------------
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", done, 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("done_edge", cyc_cnt, e.done_edge);
          check("settled", settled, e.settled);
          check("timeout", timeout, !e.settled);
          check("busy_at_done", busy, 0);
          check("settle_cycles", settle_cycles, e.sc);
          check("v_min", v_min, e.vmin);
          check("v_max", v_max, e.vmax);
        end
      end
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic run_txn(input int t, input int tl);
    exp_t e;
    e = model(t, tl);
    e.done_edge = cyc_cnt + 1 + e.k_end;
    sb_q.push_back(e);
    held_sc  = e.sc;
    start    = 1'b1;
    target_i = WIDTH'(t);
    tol_i    = WIDTH'(tl);
    v_in     = WIDTH'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= e.k_end; k++) begin
      v_in = WIDTH'(samp[k]);
      @(negedge clk);
      check("busy_track", busy, k < e.k_end);
    end
    // Post-decision samples must not disturb the result.
    repeat (3) begin
      v_in = WIDTH'($urandom);
      @(negedge clk);
    end
    check("settled_hold", settled, e.settled);
    check("timeout_hold", timeout, !e.settled);
    check("sc_hold", settle_cycles, e.sc);
    check("v_min_hold", v_min, e.vmin);
  endtask

  // Starts a tracking run that never gets in band, leaving it mid-TRACK after
  // n samples so the next start lands on edge E(n+1) of this run.
  task automatic abort_prefix(input int n);
    start    = 1'b1;
    target_i = '0;
    tol_i    = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (n) begin
      v_in = WIDTH'(1000);
      @(negedge clk);
    end
    check("busy_prefix", busy, 1);
  endtask

  task automatic fill_const(input int v);
    for (int k = 1; k <= MAX_CYC; k++) samp[k] = v;
  endtask

  task automatic fill_random(input int t, input int tl);
    int mode, conv, d;
    mode = int'($urandom_range(0, 2));
    conv = int'($urandom_range(1, MAX_CYC - HOLD_CYC));
    for (int k = 1; k <= MAX_CYC; k++) begin
      case (mode)
        0: begin
          if (k < conv) begin
            samp[k] = int'($urandom_range(0, 262143)) - 131072;
          end else begin
            d = int'($urandom_range(0, 2 * tl)) - tl;
            if ($urandom_range(0, 9) == 0) d = tl + 1 + int'($urandom_range(0, 5));
            samp[k] = clamp(t + d);
          end
        end
        1: begin
          d = int'($urandom_range(0, 4 * tl + 4)) - (2 * tl + 2);
          samp[k] = clamp(t + d);
        end
        default: samp[k] = int'($urandom_range(0, 262143)) - 131072;
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t, tl;

    // Reset held, then idle with no start.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (8) begin
      v_in = WIDTH'($urandom);
      @(negedge clk);
    end
    check("idle_busy", busy, 0);
    check("idle_settled", settled, 0);
    check("idle_timeout", timeout, 0);
    check("idle_sc", settle_cycles, 0);
    check("idle_vmin", v_min, 0);
    check("idle_vmax", v_max, 0);

    // Constant on-target input.
    fill_const(4096);
    run_txn(4096, 16);

    // Step sequence with an in-band dip and an overshoot.
    fill_const(4095);
    samp[1] = 0;    samp[2] = 2000; samp[3] = 3900;
    samp[4] = 4100; samp[5] = 4090; samp[6] = 4200;
    run_txn(4096, 16);

    // Never reaches the band.
    fill_const(0);
    run_txn(4096, 16);

    // Run completes exactly on the last allowed sample.
    fill_const(0);
    for (int k = MAX_CYC - HOLD_CYC + 1; k <= MAX_CYC; k++) samp[k] = 4096;
    run_txn(4096, 16);

    // Restart mid-TRACK: new run counted from the restart edge.
    abort_prefix(4);
    fill_const(4100);
    run_txn(4096, 16);

    // Exact-match band with a negative target.
    fill_const(-500);
    samp[2] = -499;
    run_txn(-500, 0);

    // Opposite full-scale extremes must not alias to a small error.
    fill_const(FS_NEG);
    run_txn(FS_POS, 16);

    // Widest band accepts the largest possible difference.
    fill_const(FS_POS);
    run_txn(FS_NEG, 262143);

    // Randomized transactions.
    repeat (40) begin
      t = int'($urandom_range(0, 262143)) - 131072;
      if ($urandom_range(0, 7) == 0) t = ($urandom_range(0, 1) == 0) ? FS_POS : FS_NEG;
      case ($urandom_range(0, 2))
        0:       tl = 0;
        1:       tl = 16;
        default: tl = int'($urandom_range(1, 40));
      endcase
      fill_random(t, tl);
      run_txn(t, tl);
    end

    // Reset mid-TRACK: outputs clear asynchronously, no done pulse.
    start    = 1'b1;
    target_i = WIDTH'(4096);
    tol_i    = WIDTH'(16);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      v_in = WIDTH'(4096);
      @(negedge clk);
    end
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_settled", settled, 0);
    check("arst_timeout", timeout, 0);
    check("arst_sc", settle_cycles, 0);
    check("arst_vmin", v_min, 0);
    check("arst_vmax", v_max, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    held_sc = 0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // One more transaction after reset to confirm clean recovery.
    fill_const(0);
    samp[3] = 7; samp[4] = 8; samp[5] = 9; samp[6] = 10;
    run_txn(8, 2);

    check("pending_expected", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
